// File: rtl/apple_bus_driver.sv
// Apple II slot-bus transmit side: claims reads of this slot's space, requests data from the responder
// and sequences transceiver dir/OE. Optional miss counter: APPLE_BUS_DRIVER_MISS_COUNT_EN.
module apple_bus_driver #(
    parameter int SLOT                 = 4,
    parameter bit ENABLE_EXPANSION_ROM = 1'b1,
    parameter int DRIVE_COUNT          = 4,
    parameter int HOLD_COUNT           = 2,
    parameter int DIR_GUARD            = 1
) (
    input  logic        clk_logic_i,
    input  logic        system_reset_n_i,
    input  logic        phi0_posedge_i,
    input  logic        phi0_negedge_i,
    input  logic        addr_strobe_i,
    input  logic [15:0] addr_i,
    input  logic        rw_n_i,
    output logic        rd_req_o,
    output logic [15:0] rd_addr_o,
    output logic [1:0]  rd_sel_o,
    input  logic        rd_ack_i,
    input  logic [7:0]  rd_data_i,
    output logic [7:0]  a2_d_o,
    output logic        a2_d_dir_o,
    output logic        a2_d_oe_n_o,
    output logic        expansion_en_o,
    output logic        miss_o
`ifdef APPLE_BUS_DRIVER_MISS_COUNT_EN
    ,
    output logic [15:0] miss_count_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_ACK, S_ARMED, S_DRIVE, S_HOLD, S_RELEASE
    } state_t;

    localparam logic [2:0] SLOT_B    = SLOT[2:0];
    localparam logic [5:0] DRIVE_AT  = 6'(DRIVE_COUNT);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_COUNT - 1);
    localparam logic [7:0] GRD_LAST  = 8'(DIR_GUARD - 1);

    state_t      state_q, state_d;
    logic [5:0]  phase_q, phase_d;
    logic        in_phi0_q, in_phi0_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        req_q, req_d;
    logic [15:0] raddr_q, raddr_d;
    logic [1:0]  rsel_q, rsel_d;
    logic        exp_q, exp_d;
    logic        miss_q, miss_d;
    logic        dir_q, dir_d;
    logic        oe_n_q, oe_n_d;

    logic is_devsel, is_iosel, is_cfff, is_iostrobe, claim, deadline, drive_ok;

    always_comb begin
        is_devsel   = (addr_i[15:4] == {8'hC0, 1'b1, SLOT_B});
        is_iosel    = (addr_i[15:8] == {5'b11000, SLOT_B});
        is_cfff     = (addr_i == 16'hCFFF);
        is_iostrobe = ENABLE_EXPANSION_ROM && exp_q && (addr_i[15:11] == 5'b11001) && !is_cfff;
        claim       = is_devsel || is_iosel || is_iostrobe;
        // Phase count is stale during Phi1, so every phase comparison is gated by in_phi0_q.
        deadline    = in_phi0_q && (phase_q == DRIVE_AT);
        drive_ok    = in_phi0_q && (phase_q >= DRIVE_AT) && (cnt_q >= GRD_LAST);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        data_d    = data_q;
        req_d     = 1'b0;
        raddr_d   = raddr_q;
        rsel_d    = rsel_q;
        exp_d     = exp_q;
        miss_d    = 1'b0;
        in_phi0_d = in_phi0_q;
        phase_d   = (phase_q == 6'd63) ? phase_q : phase_q + 6'd1;

        if (phi0_posedge_i) begin
            phase_d   = 6'd0;
            in_phi0_d = 1'b1;
        end else if (phi0_negedge_i) begin
            in_phi0_d = 1'b0;
        end

        if (addr_strobe_i) begin
            if (is_iosel)     exp_d = 1'b1;
            else if (is_cfff) exp_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (addr_strobe_i && rw_n_i && claim) begin
                    req_d   = 1'b1;
                    raddr_d = addr_i;
                    rsel_d  = is_devsel ? 2'd0 : (is_iosel ? 2'd1 : 2'd2);
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (rd_ack_i) begin
                    data_d  = rd_data_i;
                    cnt_d   = 8'd0;
                    state_d = S_ARMED;
                end else if (deadline) begin
                    miss_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                if (drive_ok) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (phi0_negedge_i) begin
                    cnt_d   = 8'd0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cnt_q == GRD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        dir_d  = (state_d inside {S_ARMED, S_DRIVE, S_HOLD, S_RELEASE});
        oe_n_d = !(state_d inside {S_DRIVE, S_HOLD});
    end

    always_ff @(posedge clk_logic_i) begin
        if (!system_reset_n_i) begin
            state_q   <= S_IDLE;
            phase_q   <= 6'd63;
            in_phi0_q <= 1'b0;
            cnt_q     <= 8'd0;
            data_q    <= 8'd0;
            req_q     <= 1'b0;
            raddr_q   <= 16'd0;
            rsel_q    <= 2'd0;
            exp_q     <= 1'b0;
            miss_q    <= 1'b0;
            dir_q     <= 1'b0;
            oe_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            in_phi0_q <= in_phi0_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            req_q     <= req_d;
            raddr_q   <= raddr_d;
            rsel_q    <= rsel_d;
            exp_q     <= exp_d;
            miss_q    <= miss_d;
            dir_q     <= dir_d;
            oe_n_q    <= oe_n_d;
        end
    end

`ifdef APPLE_BUS_DRIVER_MISS_COUNT_EN
    logic [15:0] miss_cnt_q;
    always_ff @(posedge clk_logic_i) begin
        if (!system_reset_n_i)                     miss_cnt_q <= 16'd0;
        else if (miss_d && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
    assign miss_count_o = miss_cnt_q;
`endif

    assign rd_req_o       = req_q;
    assign rd_addr_o      = raddr_q;
    assign rd_sel_o       = rsel_q;
    assign a2_d_o         = data_q;
    assign a2_d_dir_o     = dir_q;
    assign a2_d_oe_n_o    = oe_n_q;
    assign expansion_en_o = exp_q;
    assign miss_o         = miss_q;

endmodule

// File: tb/tb_apple_bus_driver.sv
// Bench for apple_bus_driver: each bus cycle is a fixed step schedule (strobe, Phi0 rise, Phi0 fall);
// expected event timing comes from an event-level model of the bus rules.
module tb_apple_bus_driver;

    localparam int SLOT = 4;
    localparam int DC   = 4;
    localparam int HC   = 2;
    localparam int DG   = 1;
    localparam int S    = 4;             // step carrying the phi0 rising pulse
    localparam int L    = 12;            // Phi0 length in steps
    localparam int N    = S + L;         // step carrying the phi0 falling pulse
    localparam int D    = S + 1 + DC;    // step in which the phase count equals DC
    localparam int T    = N + HC + DG + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phi0_pos = 1'b0, phi0_neg = 1'b0, strobe = 1'b0;
    logic [15:0] addr = 16'd0;
    logic        rw_n = 1'b1;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [1:0]  rd_sel;
    logic        rd_ack = 1'b0;
    logic [7:0]  rd_data = 8'd0;
    logic [7:0]  a2_d;
    logic        a2_dir, a2_oe_n, exp_en, miss;
`ifdef APPLE_BUS_DRIVER_MISS_COUNT_EN
    logic [15:0] miss_count;
`endif

    apple_bus_driver #(.SLOT(SLOT), .ENABLE_EXPANSION_ROM(1'b1), .DRIVE_COUNT(DC),
                       .HOLD_COUNT(HC), .DIR_GUARD(DG)) dut (
        .clk_logic_i(clk), .system_reset_n_i(rst_n),
        .phi0_posedge_i(phi0_pos), .phi0_negedge_i(phi0_neg),
        .addr_strobe_i(strobe), .addr_i(addr), .rw_n_i(rw_n),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_sel_o(rd_sel),
        .rd_ack_i(rd_ack), .rd_data_i(rd_data),
        .a2_d_o(a2_d), .a2_d_dir_o(a2_dir), .a2_d_oe_n_o(a2_oe_n),
        .expansion_en_o(exp_en), .miss_o(miss)
`ifdef APPLE_BUS_DRIVER_MISS_COUNT_EN
        , .miss_count_o(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference model state
    bit m_exp = 1'b0;
    int m_last_addr = 0;
    int m_last_sel = 0;
    int m_miss_cnt = 0;

    // Per-bus-cycle observations (-1 = not seen)
    int o_req_cnt, o_req_idx, o_dir_rise, o_dir_fall, o_oe_fall, o_oe_rise, o_miss_idx, o_data;
    int o_data_viol, o_inv_viol;
    logic prev_dir, prev_oe_n;

    task automatic step(input int k, input logic stb, input logic pos, input logic neg,
                        input logic ack, input logic [7:0] data, input logic rn);
        strobe = stb; phi0_pos = pos; phi0_neg = neg; rd_ack = ack; rd_data = data; rst_n = rn;
        @(posedge clk);
        #1;
        if (rd_req) begin
            if (o_req_cnt == 0) o_req_idx = k;
            o_req_cnt++;
        end
        if (a2_dir && !prev_dir && o_dir_rise < 0) o_dir_rise = k;
        if (!a2_dir && prev_dir && o_dir_fall < 0) o_dir_fall = k;
        if (!a2_oe_n && prev_oe_n && o_oe_fall < 0) begin
            o_oe_fall = k;
            o_data = int'(a2_d);
        end
        if (a2_oe_n && !prev_oe_n && o_oe_rise < 0) o_oe_rise = k;
        if (!a2_oe_n) begin
            if (int'(a2_d) != o_data) o_data_viol++;
            if (!a2_dir) o_inv_viol++;
        end
        if (miss && o_miss_idx < 0) o_miss_idx = k;
        prev_dir = a2_dir;
        prev_oe_n = a2_oe_n;
    endtask

    task automatic run_bus(input logic [15:0] a, input logic rw, input int ack_step,
                           input logic [7:0] ack_data, input int rst_step);
        int ai;
        bit iosel, devsel, strb, claimed, exp_req, ontime;
        int e_miss, e_dir_rise, e_oe_fall, e_oe_rise, e_dir_fall, e_data;
        o_req_cnt = 0; o_req_idx = -1; o_dir_rise = -1; o_dir_fall = -1; o_oe_fall = -1;
        o_oe_rise = -1; o_miss_idx = -1; o_data = -1; o_data_viol = 0; o_inv_viol = 0;
        prev_dir = a2_dir; prev_oe_n = a2_oe_n;
        addr = a; rw_n = rw;

        ai      = int'(a);
        iosel   = (ai >= 'hC000 + SLOT * 256) && (ai <= 'hC0FF + SLOT * 256);
        devsel  = (ai >= 'hC080 + SLOT * 16) && (ai <= 'hC08F + SLOT * 16);
        strb    = (ai >= 'hC800) && (ai <= 'hCFFE);
        claimed = devsel || iosel || (strb && m_exp);
        exp_req = claimed && rw;
        if (iosel) m_exp = 1'b1;
        else if (ai == 'hCFFF) m_exp = 1'b0;
        if (exp_req) begin
            m_last_addr = ai;
            m_last_sel  = devsel ? 0 : (iosel ? 1 : 2);
        end
        ontime     = exp_req && ack_step >= 1 && ack_step <= D;
        e_miss     = (exp_req && !ontime) ? D : -1;
        if (e_miss >= 0) m_miss_cnt++;
        e_dir_rise = ontime ? ack_step : -1;
        e_oe_fall  = ontime ? ((ack_step + DG > D) ? ack_step + DG : D) : -1;
        e_oe_rise  = ontime ? N + HC : -1;
        e_dir_fall = ontime ? N + HC + DG : -1;
        e_data     = ontime ? int'(ack_data) : -1;

        for (int k = 0; k < T; k++) begin
            step(k, k == 0, k == S, k == N, k == ack_step,
                 (k == ack_step) ? ack_data : 8'($urandom), !(k == rst_step));
            if (k == rst_step) begin
                check_eq("rst_mid_oe_n", int'(a2_oe_n), 1);
                check_eq("rst_mid_dir", int'(a2_dir), 0);
                check_eq("rst_mid_exp", int'(exp_en), 0);
                check_eq("rst_mid_data", int'(a2_d), 0);
            end
        end

        if (rst_step >= 0) begin
            m_exp = 1'b0; m_last_addr = 0; m_last_sel = 0; m_miss_cnt = 0;
            check_eq("post_rst_oe_n", int'(a2_oe_n), 1);
            check_eq("post_rst_dir", int'(a2_dir), 0);
            check_eq("post_rst_rd_addr", int'(rd_addr), 0);
        end else begin
            check_eq("req_cnt", o_req_cnt, exp_req ? 1 : 0);
            check_eq("req_idx", o_req_idx, exp_req ? 0 : -1);
            check_eq("rd_addr", int'(rd_addr), m_last_addr);
            check_eq("rd_sel", int'(rd_sel), m_last_sel);
            check_eq("miss_idx", o_miss_idx, e_miss);
            check_eq("dir_rise", o_dir_rise, e_dir_rise);
            check_eq("oe_fall", o_oe_fall, e_oe_fall);
            check_eq("oe_rise", o_oe_rise, e_oe_rise);
            check_eq("dir_fall", o_dir_fall, e_dir_fall);
            check_eq("bus_data", o_data, e_data);
            check_eq("data_stable", o_data_viol, 0);
            check_eq("oe_implies_dir", o_inv_viol, 0);
        end
        check_eq("expansion_en", int'(exp_en), int'(m_exp));
`ifdef APPLE_BUS_DRIVER_MISS_COUNT_EN
        check_eq("miss_count", int'(miss_count), (m_miss_cnt > 65535) ? 65535 : m_miss_cnt);
`endif
    endtask

    initial begin
        logic [15:0] ra;
        logic        rrw;
        int          rack;

        o_req_cnt = 0; o_req_idx = -1; o_dir_rise = -1; o_dir_fall = -1; o_oe_fall = -1;
        o_oe_rise = -1; o_miss_idx = -1; o_data = -1; o_data_viol = 0; o_inv_viol = 0;
        prev_dir = 1'b0; prev_oe_n = 1'b1;
        for (int k = 0; k < 3; k++) step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        check_eq("reset_oe_n", int'(a2_oe_n), 1);
        check_eq("reset_dir", int'(a2_dir), 0);
        check_eq("reset_data", int'(a2_d), 0);
        check_eq("reset_req", int'(rd_req), 0);
        check_eq("reset_rd_addr", int'(rd_addr), 0);
        check_eq("reset_rd_sel", int'(rd_sel), 0);
        check_eq("reset_exp", int'(exp_en), 0);
        check_eq("reset_miss", int'(miss), 0);
        for (int k = 0; k < 2; k++) step(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        run_bus(16'hC0C3, 1'b1, 3, 8'hA5, -1);      // DEVSEL read, ack after two cycles
        run_bus(16'hC800, 1'b1, 3, 8'h11, -1);      // latch clear: unclaimed
        run_bus(16'hC400, 1'b1, 3, 8'h22, -1);      // IOSEL read sets latch
        run_bus(16'hC800, 1'b1, 3, 8'h33, -1);      // IOSTROBE read
        run_bus(16'hCFFF, 1'b0, -1, 8'h00, -1);     // clears latch
        run_bus(16'hC800, 1'b1, 3, 8'h44, -1);
        run_bus(16'hC0C0, 1'b0, 3, 8'h55, -1);      // write: no request
        run_bus(16'hC0C1, 1'b1, -1, 8'h00, -1);     // no ack: miss
        run_bus(16'hC0C2, 1'b1, D, 8'h66, -1);      // ack on the deadline
        run_bus(16'hC0C2, 1'b1, D + 1, 8'h77, -1);  // ack one late: miss
        run_bus(16'hC403, 1'b1, 3, 8'h88, N - 2);   // reset during DRIVE
        run_bus(16'hC0C5, 1'b1, 4, 8'h99, -1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'hC0C0 | 16'($urandom_range(0, 15));
                1: ra = 16'hC400 | 16'($urandom_range(0, 255));
                2: ra = 16'hC800 + 16'($urandom_range(0, 16'h7FE));
                3: ra = 16'hCFFF;
                4: ra = 16'($urandom);
                default: ra = 16'hC080 + 16'($urandom_range(0, 127));
            endcase
            rrw  = ($urandom_range(0, 3) != 0);
            rack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(2, D + 2));
            run_bus(ra, rrw, rack, 8'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
